zx_bus_update_sequencer: RTL and testbench

- Clocked controller on the MCU side of the ZX bus CPLD interface.
- Serialises update requests from three requesters (keyboard matrix events, Kempston mouse snapshots, Kempston joystick state) onto the shared CPLD load interface:
  - shared 8-bit data bus with MX/MY/MKEY/JOY rising-edge strobes;
  - CH446Q-style serial keyboard link DAT/SK/STB.
- Round-robin arbitration between requesters; only one transaction is on the wires at a time.

---
 rtl/zx_bus_update_sequencer.sv | 174 +++++++++++++++++
 tb/tb_zx_bus_update_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/zx_bus_update_sequencer.sv
// MCU-side sequencer for the ZX bus CPLD: round-robin arbitration of keyboard, mouse and
// joystick updates onto the shared parallel load bus and the serial keyboard link.
module zx_bus_update_sequencer #(
   parameter int HALF = 2
) (
   input  logic       CLK,
   input  logic       RST_IN,
   input  logic       KEY_REQ,
   input  logic [3:0] KEY_AX,
   input  logic [2:0] KEY_AY,
   input  logic       KEY_ON,
   output logic       KEY_ACK,
   input  logic       MOUSE_REQ,
   input  logic [7:0] MOUSE_X,
   input  logic [7:0] MOUSE_Y,
   input  logic [7:0] MOUSE_KEY,
   output logic       MOUSE_ACK,
   input  logic       JOY_REQ,
   input  logic [7:0] JOY_DATA,
   output logic       JOY_ACK,
   output logic [7:0] DO,
   output logic       MX,
   output logic       MY,
   output logic       MKEY,
   output logic       JOY,
   output logic       DAT,
   output logic       SK,
   output logic       STB,
   output logic       BUSY
);

   typedef enum logic [3:0] {
      S_IDLE, S_K_SETUP, S_K_HIGH, S_K_LOW, S_K_DSETUP, S_K_STBH, S_K_STBL,
      S_B_SETUP, S_B_HIGH, S_B_HOLD
   } state_t;

   localparam logic [1:0] SLOT_MX   = 2'd0;
   localparam logic [1:0] SLOT_MY   = 2'd1;
   localparam logic [1:0] SLOT_MKEY = 2'd2;
   localparam logic [1:0] SLOT_JOY  = 2'd3;

   state_t      state_q, state_nx;
   logic [7:0]  timer_q;
   logic [1:0]  ptr_q;
   logic        rest_q;
   logic [2:0]  bit_q;
   logic [1:0]  slot_q;
   logic [6:0]  shift_q;
   logic        key_on_q;
   logic [7:0]  pay_q [3];
   logic [7:0]  bus_val;
   logic [2:0]  req_vec;
   logic        grant_any;
   logic [1:0]  grant_idx;
   logic        phase_end;

   function automatic logic [1:0] wrap_add(input logic [1:0] base, input logic [1:0] ofs);
      logic [2:0] s;
      s = {1'b0, base} + {1'b0, ofs};
      if (s >= 3'd3) s = s - 3'd3;
      return s[1:0];
   endfunction

   assign req_vec   = {JOY_REQ, MOUSE_REQ, KEY_REQ};
   assign phase_end = (timer_q == 8'(HALF - 1));

   // Scan from the pointer; the lowest offset with an active request wins.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = ptr_q;
      if (RST_IN && state_q == S_IDLE && !rest_q) begin
         for (int i = 2; i >= 0; i--) begin
            if (req_vec[wrap_add(ptr_q, 2'(i))]) begin
               grant_any = 1'b1;
               grant_idx = wrap_add(ptr_q, 2'(i));
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_IN) begin
         state_q <= S_IDLE;
         timer_q <= 8'd0;
         ptr_q   <= 2'd0;
         rest_q  <= 1'b0;
      end else begin
         state_q <= state_nx;
         timer_q <= (state_q != S_IDLE && !phase_end) ? timer_q + 8'd1 : 8'd0;
         rest_q  <= (state_q != S_IDLE && state_nx == S_IDLE);
         if (grant_any) ptr_q <= wrap_add(grant_idx, 2'd1);
      end
   end

   always_comb begin
      state_nx = state_q;
      case (state_q)
         S_IDLE:     if (grant_any) state_nx = (grant_idx == 2'd0) ? S_K_SETUP : S_B_SETUP;
         S_K_SETUP:  if (phase_end) state_nx = S_K_HIGH;
         S_K_HIGH:   if (phase_end) state_nx = S_K_LOW;
         S_K_LOW:    if (phase_end) state_nx = (bit_q == 3'd6) ? S_K_DSETUP : S_K_SETUP;
         S_K_DSETUP: if (phase_end) state_nx = S_K_STBH;
         S_K_STBH:   if (phase_end) state_nx = S_K_STBL;
         S_K_STBL:   if (phase_end) state_nx = S_IDLE;
         S_B_SETUP:  if (phase_end) state_nx = S_B_HIGH;
         S_B_HIGH:   if (phase_end) state_nx = S_B_HOLD;
         S_B_HOLD:   if (phase_end)
                        state_nx = (slot_q == SLOT_MX || slot_q == SLOT_MY) ? S_B_SETUP : S_IDLE;
         default:    state_nx = S_IDLE;
      endcase
   end

   // Payload is frozen at grant; the joystick byte reuses the first bus slot.
   always_ff @(posedge CLK) begin
      if (grant_any) begin
         bit_q    <= 3'd0;
         shift_q  <= {KEY_AY, KEY_AX};
         key_on_q <= KEY_ON;
         slot_q   <= (grant_idx == 2'd2) ? SLOT_JOY : SLOT_MX;
         pay_q[0] <= (grant_idx == 2'd2) ? JOY_DATA : MOUSE_X;
         pay_q[1] <= MOUSE_Y;
         pay_q[2] <= MOUSE_KEY;
      end else if (phase_end) begin
         if (state_q == S_K_LOW) begin
            bit_q   <= bit_q + 3'd1;
            shift_q <= {shift_q[5:0], 1'b0};
         end
         if (state_q == S_B_HOLD) slot_q <= slot_q + 2'd1;
      end
   end

   assign bus_val = (slot_q == SLOT_MY)   ? pay_q[1] :
                    (slot_q == SLOT_MKEY) ? pay_q[2] : pay_q[0];

   always_comb begin
      DO   = 8'hFF;
      MX   = 1'b0;
      MY   = 1'b0;
      MKEY = 1'b0;
      JOY  = 1'b0;
      DAT  = 1'b0;
      SK   = 1'b0;
      STB  = 1'b0;
      case (state_q)
         S_K_SETUP, S_K_LOW:   DAT = shift_q[6];
         S_K_HIGH: begin
            DAT = shift_q[6];
            SK  = 1'b1;
         end
         S_K_DSETUP, S_K_STBL: DAT = key_on_q;
         S_K_STBH: begin
            DAT = key_on_q;
            STB = 1'b1;
         end
         S_B_SETUP, S_B_HOLD:  DO = bus_val;
         S_B_HIGH: begin
            DO = bus_val;
            case (slot_q)
               SLOT_MX:   MX   = 1'b1;
               SLOT_MY:   MY   = 1'b1;
               SLOT_MKEY: MKEY = 1'b1;
               default:   JOY  = 1'b1;
            endcase
         end
         default: ;
      endcase
   end

   assign KEY_ACK   = grant_any && grant_idx == 2'd0;
   assign MOUSE_ACK = grant_any && grant_idx == 2'd1;
   assign JOY_ACK   = grant_any && grant_idx == 2'd2;
   assign BUSY      = grant_any || state_q != S_IDLE;

endmodule

// File: tb/tb_zx_bus_update_sequencer.sv
// Directed bench for zx_bus_update_sequencer: one HALF=2 instance for the main sequences and
// one HALF=1 instance for the minimum-timing joystick case.
module tb_zx_bus_update_sequencer;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic       RST_IN;
   logic       KEY_REQ, KEY_ON, KEY_ACK;
   logic [3:0] KEY_AX;
   logic [2:0] KEY_AY;
   logic       MOUSE_REQ, MOUSE_ACK;
   logic [7:0] MOUSE_X, MOUSE_Y, MOUSE_KEY;
   logic       JOY_REQ, JOY_ACK;
   logic [7:0] JOY_DATA;
   logic [7:0] DO;
   logic       MX, MY, MKEY, JOY, DAT, SK, STB, BUSY;

   logic       j1_req, j1_key_ack, j1_mouse_ack, j1_joy_ack;
   logic [7:0] j1_data, j1_do;
   logic       j1_mx, j1_my, j1_mkey, j1_joy, j1_dat, j1_sk, j1_stb, j1_busy;

   zx_bus_update_sequencer #(.HALF(2)) dut (
      .CLK(CLK), .RST_IN(RST_IN),
      .KEY_REQ(KEY_REQ), .KEY_AX(KEY_AX), .KEY_AY(KEY_AY), .KEY_ON(KEY_ON), .KEY_ACK(KEY_ACK),
      .MOUSE_REQ(MOUSE_REQ), .MOUSE_X(MOUSE_X), .MOUSE_Y(MOUSE_Y), .MOUSE_KEY(MOUSE_KEY),
      .MOUSE_ACK(MOUSE_ACK),
      .JOY_REQ(JOY_REQ), .JOY_DATA(JOY_DATA), .JOY_ACK(JOY_ACK),
      .DO(DO), .MX(MX), .MY(MY), .MKEY(MKEY), .JOY(JOY),
      .DAT(DAT), .SK(SK), .STB(STB), .BUSY(BUSY)
   );

   zx_bus_update_sequencer #(.HALF(1)) dut1 (
      .CLK(CLK), .RST_IN(RST_IN),
      .KEY_REQ(1'b0), .KEY_AX(KEY_AX), .KEY_AY(KEY_AY), .KEY_ON(KEY_ON), .KEY_ACK(j1_key_ack),
      .MOUSE_REQ(1'b0), .MOUSE_X(MOUSE_X), .MOUSE_Y(MOUSE_Y), .MOUSE_KEY(MOUSE_KEY),
      .MOUSE_ACK(j1_mouse_ack),
      .JOY_REQ(j1_req), .JOY_DATA(j1_data), .JOY_ACK(j1_joy_ack),
      .DO(j1_do), .MX(j1_mx), .MY(j1_my), .MKEY(j1_mkey), .JOY(j1_joy),
      .DAT(j1_dat), .SK(j1_sk), .STB(j1_stb), .BUSY(j1_busy)
   );

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   int         busy_cnt, sk_n, stb_n, mx_n, my_n, mk_n, jy_n;
   int         overlap, do_glitch, do_active, strobe_any, multi_ack;
   logic [6:0] sk_bits;
   logic       stb_dat;
   logic [7:0] mx_do, my_do, mk_do, jy_do;
   int         grants[$];

   // Samples the HALF=2 instance once per cycle, starting with the current (already settled) cycle.
   task automatic observe(input int ncyc, input bit drop);
      logic p_mx, p_my, p_mk, p_jy, p_sk, p_stb, cur_any, prev_any;
      logic [7:0] p_do;
      int s;
      busy_cnt = 0; sk_n = 0; stb_n = 0; mx_n = 0; my_n = 0; mk_n = 0; jy_n = 0;
      overlap = 0; do_glitch = 0; do_active = 0; strobe_any = 0; multi_ack = 0;
      sk_bits = 7'd0; stb_dat = 1'b0;
      mx_do = 8'd0; my_do = 8'd0; mk_do = 8'd0; jy_do = 8'd0;
      grants.delete();
      p_mx = 1'b0; p_my = 1'b0; p_mk = 1'b0; p_jy = 1'b0; p_sk = 1'b0; p_stb = 1'b0;
      p_do = DO;
      for (int c = 0; c < ncyc; c++) begin
         if (c > 0) begin
            @(negedge CLK);
            if (drop) begin
               KEY_REQ = 1'b0; MOUSE_REQ = 1'b0; JOY_REQ = 1'b0;
            end
            #1;
         end
         if (BUSY) busy_cnt++;
         if (KEY_ACK)   grants.push_back(0);
         if (MOUSE_ACK) grants.push_back(1);
         if (JOY_ACK)   grants.push_back(2);
         if (int'(KEY_ACK) + int'(MOUSE_ACK) + int'(JOY_ACK) > 1) multi_ack++;
         s = int'(MX) + int'(MY) + int'(MKEY) + int'(JOY) + int'(SK) + int'(STB);
         if (s > 1) overlap++;
         if (s > 0) strobe_any++;
         if (DO !== 8'hFF) do_active++;
         if (SK && !p_sk)   begin sk_bits = {sk_bits[5:0], DAT}; sk_n++; end
         if (STB && !p_stb) begin stb_dat = DAT; stb_n++; end
         if (MX && !p_mx)   begin mx_do = DO; mx_n++; end
         if (MY && !p_my)   begin my_do = DO; my_n++; end
         if (MKEY && !p_mk) begin mk_do = DO; mk_n++; end
         if (JOY && !p_jy)  begin jy_do = DO; jy_n++; end
         cur_any  = MX | MY | MKEY | JOY;
         prev_any = p_mx | p_my | p_mk | p_jy;
         if ((cur_any || prev_any) && DO !== p_do) do_glitch++;
         p_mx = MX; p_my = MY; p_mk = MKEY; p_jy = JOY; p_sk = SK; p_stb = STB; p_do = DO;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int j1_busy_n, j1_hi_n, j1_hi_pos;
      logic [7:0] j1_hi_do;

      RST_IN = 1'b0;
      KEY_REQ = 1'b0; KEY_AX = 4'd0; KEY_AY = 3'd0; KEY_ON = 1'b0;
      MOUSE_REQ = 1'b0; MOUSE_X = 8'd0; MOUSE_Y = 8'd0; MOUSE_KEY = 8'd0;
      JOY_REQ = 1'b0; JOY_DATA = 8'd0;
      j1_req = 1'b0; j1_data = 8'h3C;

      repeat (3) @(negedge CLK);
      #1;
      chk("rst_do", 32'(DO), 32'hFF);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_lines", 32'({MX, MY, MKEY, JOY, DAT, SK, STB}), 32'd0);
      chk("rst_acks", 32'({KEY_ACK, MOUSE_ACK, JOY_ACK}), 32'd0);

      @(negedge CLK); RST_IN = 1'b1; #1;
      observe(20, 1'b1);
      chk("idle_busy", 32'(busy_cnt), 32'd0);
      chk("idle_do", 32'(do_active), 32'd0);
      chk("idle_strobes", 32'(strobe_any), 32'd0);

      // Matrix key AX=3 AY=2 pressed: address 0100011, then DAT=1 at STB.
      @(negedge CLK);
      KEY_AX = 4'd3; KEY_AY = 3'd2; KEY_ON = 1'b1; KEY_REQ = 1'b1; #1;
      chk("key_ack", 32'(KEY_ACK), 32'd1);
      observe(60, 1'b1);
      chk("key_ack_cnt", 32'(grants.size()), 32'd1);
      chk("key_sk_n", 32'(sk_n), 32'd7);
      chk("key_bits", 32'(sk_bits), 32'b0100011);
      chk("key_stb_n", 32'(stb_n), 32'd1);
      chk("key_stb_dat", 32'(stb_dat), 32'd1);
      chk("key_busy", 32'(busy_cnt), 32'd49);
      chk("key_do", 32'(do_active), 32'd0);
      chk("key_overlap", 32'(overlap), 32'd0);

      // Special line AX=8 AY=6 (RESET): address 1101000.
      @(negedge CLK);
      KEY_AX = 4'd8; KEY_AY = 3'd6; KEY_ON = 1'b1; KEY_REQ = 1'b1; #1;
      chk("spc_ack", 32'(KEY_ACK), 32'd1);
      observe(60, 1'b1);
      chk("spc_bits", 32'(sk_bits), 32'b1101000);
      chk("spc_sk_n", 32'(sk_n), 32'd7);
      chk("spc_stb_dat", 32'(stb_dat), 32'd1);
      chk("spc_do", 32'(do_active), 32'd0);

      // Mouse snapshot.
      @(negedge CLK);
      MOUSE_X = 8'h80; MOUSE_Y = 8'h60; MOUSE_KEY = 8'hFE; MOUSE_REQ = 1'b1; #1;
      chk("mou_ack", 32'(MOUSE_ACK), 32'd1);
      observe(25, 1'b1);
      chk("mou_mx_n", 32'(mx_n), 32'd1);
      chk("mou_my_n", 32'(my_n), 32'd1);
      chk("mou_mk_n", 32'(mk_n), 32'd1);
      chk("mou_mx_do", 32'(mx_do), 32'h80);
      chk("mou_my_do", 32'(my_do), 32'h60);
      chk("mou_mk_do", 32'(mk_do), 32'hFE);
      chk("mou_busy", 32'(busy_cnt), 32'd19);
      chk("mou_glitch", 32'(do_glitch), 32'd0);
      chk("mou_sk", 32'(sk_n + stb_n), 32'd0);
      chk("mou_overlap", 32'(overlap), 32'd0);

      // Reset while MX is high.
      @(negedge CLK); MOUSE_REQ = 1'b1; #1;
      chk("abt_ack", 32'(MOUSE_ACK), 32'd1);
      observe(4, 1'b1);
      chk("abt_mx_seen", 32'(mx_n), 32'd1);
      chk("abt_mx_now", 32'(MX), 32'd1);
      @(negedge CLK); RST_IN = 1'b0; MOUSE_REQ = 1'b1; #1;
      @(negedge CLK); #1;
      chk("abt_strobes", 32'({MX, MY, MKEY, JOY}), 32'd0);
      chk("abt_do", 32'(DO), 32'hFF);
      chk("abt_busy", 32'(BUSY), 32'd0);
      chk("abt_ack_gated", 32'(MOUSE_ACK), 32'd0);

      // All three requesters held from reset.
      KEY_AX = 4'd1; KEY_AY = 3'd4; KEY_ON = 1'b0; KEY_REQ = 1'b1;
      JOY_DATA = 8'hA5; JOY_REQ = 1'b1;
      @(negedge CLK); RST_IN = 1'b1; #1;
      chk("rr_first", 32'(KEY_ACK), 32'd1);
      observe(80, 1'b0);
      chk("rr_n", 32'(grants.size()), 32'd4);
      chk("rr_g0", grants[0], 32'd0);
      chk("rr_g1", grants[1], 32'd1);
      chk("rr_g2", grants[2], 32'd2);
      chk("rr_g3", grants[3], 32'd0);
      chk("rr_joy_n", 32'(jy_n), 32'd1);
      chk("rr_joy_do", 32'(jy_do), 32'hA5);
      chk("rr_overlap", 32'(overlap), 32'd0);
      chk("rr_multi_ack", 32'(multi_ack), 32'd0);
      chk("rr_glitch", 32'(do_glitch), 32'd0);
      observe(60, 1'b1);
      chk("rr_drain", 32'(grants.size()), 32'd0);
      chk("rr_idle", 32'(BUSY), 32'd0);

      // HALF=1 joystick pulse.
      @(negedge CLK); j1_req = 1'b1; #1;
      chk("j1_ack", 32'(j1_joy_ack), 32'd1);
      chk("j1_busy0", 32'(j1_busy), 32'd1);
      j1_busy_n = 1; j1_hi_n = 0; j1_hi_pos = 0; j1_hi_do = 8'd0;
      for (int c = 1; c < 7; c++) begin
         @(negedge CLK); j1_req = 1'b0; #1;
         if (j1_busy) j1_busy_n++;
         if (j1_joy) begin
            j1_hi_n++;
            j1_hi_pos = c;
            j1_hi_do = j1_do;
         end
      end
      chk("j1_busy", 32'(j1_busy_n), 32'd4);
      chk("j1_hi_n", 32'(j1_hi_n), 32'd1);
      chk("j1_hi_pos", 32'(j1_hi_pos), 32'd2);
      chk("j1_do", 32'(j1_hi_do), 32'h3C);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
